mem_block_copy: RTL
===================

Name: mem_block_copy

Overview:
- Bus master for one port of the dual-port instruction/data memory.
- Copies `count` 32-bit words from `src_addr` to `dst_addr` by alternating read and write cycles on that single port.
- The other memory port stays free for the CPU pipeline.
- Used for program loading, relocating code from data space into instruction space (0x4000_0000 region), and bulk data moves.

Parameters:
- N, 32, address/data bus width.
- CNT_W, 16, width of the word-count input and the internal remaining-word counter.

Ports:
- clk  input  1  system clock.
- rstb  input  1  reset.
- start  input  1  request pulse; sampled only in IDLE.
- src_addr  input  N  byte address of the first source word.
- dst_addr  input  N  byte address of the first destination word.
- count  input  CNT_W  number of words to copy.
- busy  output  1  high from the cycle after an accepted start through the DONE cycle.
- done  output  1  one-cycle completion pulse.
- error  output  1  misaligned request flag; valid while done=1, held until the next accepted start.
- mem_wr_ena  output  1  memory write enable.
- mem_addr  output  N  memory byte address.
- mem_din  output  N  memory write data.
- mem_dout  input  N  memory read data; valid 1 cycle after mem_addr is presented.

Interface rules:
- One clock; reset is synchronous and active-high.
- The reset port keeps the codebase name `rstb` but is active-high: rstb=1 at a clk edge resets.

Behaviour:
- Reset values: state=IDLE; busy, done, error, mem_wr_ena = 0; mem_addr, mem_din = 0; internal pointers and counter = 0.
- Reset has priority over everything, including mid-copy: the FSM returns to IDLE, no further writes occur, no done pulse is issued, and words already written stay written.
- IDLE:
  - mem_wr_ena=0 and mem_addr=0.
  - On start=1, latch src_ptr, dst_ptr and rem=count.
  - If src_addr[1:0]!=0 or dst_addr[1:0]!=0, set error=1 and go to DONE with no memory access.
  - Else if count==0, clear error and go to DONE.
  - Else clear error and go to RD.
- RD:
  - mem_addr=src_ptr, mem_wr_ena=0.
  - Go to WR.
- WR:
  - mem_addr=dst_ptr, mem_wr_ena=1, mem_din=mem_dout (the word read in the previous RD cycle; combinational pass-through, no extra register).
  - Then src_ptr+=4, dst_ptr+=4, rem-=1.
  - If rem==1 before the decrement, go to DONE; else go to RD.
- DONE:
  - done=1, busy=1, mem_wr_ena=0.
  - Go to IDLE unconditionally.
- Latency: start accepted at edge E0. Word k (0-based) is read in cycle E0+1+2k and written in cycle E0+2+2k. done is asserted in cycle E0+2·count+1.
- start while busy: ignored, never queued. start asserted during the DONE cycle: ignored.
- Pointers wrap modulo 2^N. No check is made for crossing between instruction and data space; the memory decodes each address independently.
- Overlap: the copy is strictly ascending. If dst_addr is in (src_addr, src_addr+4·count), source words are overwritten before they are read; this is defined behaviour, not an error.
- mem_addr, mem_wr_ena and mem_din are decoded only from registered state and pointers (mem_din also from mem_dout), so there is no combinational path from start to the memory.

Decomposition:
- Shared package/include holds:
  - FSM state encoding (IDLE, RD, WR, DONE, 2 bits).
  - WORD_BYTES=4.
  - The existing I_START_ADDRESS define (0x400), which the testbench uses to build instruction-space addresses.
- No sub-module: a single FSM, two pointer registers and one down-counter.

Test Plan:
- Basic copy:
  - Stimulus: DMEM words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; start with src=0x0, dst=0x100, count=4.
  - Response: DMEM[0x40..0x43] match the source; done in cycle E0+9; busy high for cycles E0+1..E0+9; error=0.
- Data to instruction space:
  - Stimulus: src=0x0000_0010, dst=0x4000_0000, count=2.
  - Response: IMEM[0..1] = DMEM[4..5]; the writes drive mem_addr 0x4000_0000 then 0x4000_0004.
- Zero count and misaligned:
  - Stimulus: count=0.
  - Response: done at E0+1, error=0, no mem_wr_ena pulse.
  - Stimulus: src=0x2, count=5.
  - Response: done at E0+1, error=1, no memory access.
- Reset mid-copy:
  - Stimulus: count=8; assert rstb at E0+6 for 1 cycle.
  - Response: exactly 2 words written; all outputs 0 the next cycle; no done pulse.
  - Stimulus: a subsequent start with count=1.
  - Response: completes normally.
- start while busy and overlap:
  - Stimulus: a second start pulse at E0+3 during a count=3 copy.
  - Response: ignored; exactly 6 memory cycles occur.
  - Stimulus: overlap copy with src=0x0, dst=0x4, count=3, and DMEM[0]=A.
  - Response: DMEM[1..3]=A,A,A.
- Address wrap:
  - Stimulus: src=0xFFFF_FFF8, dst=0x200, count=3.
  - Response: reads occur at 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000, and the third word is written to 0x208.

Source files
------------

// File: rtl/mem_block_copy_pkg.sv
// Purpose : shared definitions for the single-port memory block copier.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding, the word size in bytes and the instruction
// space start constant that software and the bench use to form addresses in
// the 0x4000_0000 region.

`ifndef I_START_ADDRESS
`define I_START_ADDRESS 32'h0000_0400
`endif

package mem_block_copy_pkg;

    // Bytes per memory word; pointers advance by this amount per copied word.
    localparam int WORD_BYTES = 4;

    // Instruction space base in units of 1 MiB: 0x400 << 20 = 0x4000_0000.
    localparam logic [31:0] I_START_ADDRESS = `I_START_ADDRESS;
    localparam int          I_SPACE_SHIFT   = 20;

    // Copier FSM. One RD/WR pair per copied word; DONE lasts exactly one cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_e;

    // A byte address is word aligned when its two low bits are zero.
    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/mem_block_copy.sv
// Purpose : bus master on one port of the dual-port I/D memory that copies
//           `count` words from src_addr to dst_addr, one RD then one WR cycle
//           per word, leaving the other port free for the CPU pipeline.
// Latency : start accepted at edge E0; word k read in cycle E0+1+2k, written
//           in cycle E0+2+2k; done pulses in cycle E0+2*count+1.
// Backpressure: none; the memory port is assumed always ready. start is only
//           sampled in IDLE, anything arriving while busy is dropped.
//
// Ports:
//   clk, rstb          clock; synchronous reset, active-high despite the name
//   start              request pulse (IDLE only)
//   src_addr/dst_addr  byte addresses of first source/destination words
//   count              number of words to copy (0 allowed)
//   busy/done/error    status; error = misaligned request, held until next start
//   mem_wr_ena/mem_addr/mem_din  memory port drive, decoded from registers only
//   mem_dout           memory read data, one cycle after mem_addr

module mem_block_copy
    import mem_block_copy_pkg::*;
#(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             start,
    input  logic [N-1:0]     src_addr,
    input  logic [N-1:0]     dst_addr,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             mem_wr_ena,
    output logic [N-1:0]     mem_addr,
    output logic [N-1:0]     mem_din,
    input  logic [N-1:0]     mem_dout
);

    localparam logic [N-1:0]     PTR_STEP = N'(WORD_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [N-1:0]       src_ptr_q, src_ptr_d;
    logic [N-1:0]       dst_ptr_q, dst_ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               error_q, error_d;

    logic               req_aligned;
    logic               req_empty;

    assign req_aligned = is_word_aligned(src_addr[1:0]) &&
                         is_word_aligned(dst_addr[1:0]);
    assign req_empty   = (count == '0);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        src_ptr_d = src_ptr_q;
        dst_ptr_d = dst_ptr_q;
        rem_d     = rem_q;
        error_d   = error_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    src_ptr_d = src_addr;
                    dst_ptr_d = dst_addr;
                    rem_d     = count;
                    if (!req_aligned) begin
                        // Reject without touching memory; DONE still pulses
                        // so software always sees a completion.
                        error_d = 1'b1;
                        state_d = DONE;
                    end else if (req_empty) begin
                        error_d = 1'b0;
                        state_d = DONE;
                    end else begin
                        error_d = 1'b0;
                        state_d = RD;
                    end
                end
            end

            RD: begin
                state_d = WR;
            end

            WR: begin
                // Pointers wrap naturally at 2^N; no I/D space crossing check.
                src_ptr_d = src_ptr_q + PTR_STEP;
                dst_ptr_d = dst_ptr_q + PTR_STEP;
                rem_d     = rem_q - CNT_ONE;
                state_d   = (rem_q == CNT_ONE) ? DONE : RD;
            end

            DONE: begin
                // A start seen here is dropped, not queued.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers; reset wins over everything, including a copy in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q   <= IDLE;
            src_ptr_q <= '0;
            dst_ptr_q <= '0;
            rem_q     <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_ptr_q <= src_ptr_d;
            dst_ptr_q <= dst_ptr_d;
            rem_q     <= rem_d;
            error_q   <= error_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Decoded from registered state only, so start never reaches
    // the memory port combinationally. mem_din is a straight pass-through
    // of the word fetched in the preceding RD cycle.
    // ------------------------------------------------------------------
    always_comb begin
        mem_wr_ena = 1'b0;
        mem_addr   = '0;
        mem_din    = '0;

        unique case (state_q)
            RD: begin
                mem_addr = src_ptr_q;
            end
            WR: begin
                mem_addr   = dst_ptr_q;
                mem_wr_ena = 1'b1;
                mem_din    = mem_dout;
            end
            default: begin
                mem_wr_ena = 1'b0;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign error = error_q;

endmodule
